fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the single-issue RV32I core. It owns the program counter and drives the word address into the combinational instruction memory. Each returned instruction word, tagged with its PC, goes into a small in-order fetch queue that feeds decode through a valid/ready handshake. Decode or execute can redirect fetch with a new PC (branch, jump or trap), which flushes the queue.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, fetch queue entries; power of two, minimum 2.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  when low, no new fetches are issued; queued entries still drain.
- imem_pc  out  32  address to instruction memory; always equals the internal PC register.
- imem_instr  in  32  instruction word returned combinationally for imem_pc in the same cycle.
- redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are forced to 0 on load.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction word of the head entry.
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32.

## Operation
- Internal state:
  - PC register `pc`.
  - Circular queue of DEPTH entries {pc, instr}, with read pointer `rd_ptr` and write pointer `wr_ptr`, each log2(DEPTH) bits wide.
  - Occupancy `count`, 0..DEPTH.
- Pop: pop = out_valid && out_ready.
- Push: push = fetch_en && !redirect_valid && (count < DEPTH || pop).
  - A full queue still accepts a fetch in the same cycle it pops.
- On push:
  - Write {pc, imem_instr} at wr_ptr.
  - Advance wr_ptr.
  - pc <= pc + 4. The PC wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- On pop: advance rd_ptr. Both pointers wrap naturally at DEPTH.
- count update:
  - count + 1 on push only.
  - count − 1 on pop only.
  - Unchanged when push and pop happen together, or when neither happens.
- Redirect has priority over all other activity in its cycle:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - rd_ptr, wr_ptr and count are cleared to 0.
  - No push that cycle.
  - A pop asserted in the same cycle is still a legal handshake for the old head: decode consumes it, then the queue is flushed.
- Outputs are combinational from the head entry:
  - out_valid = (count != 0).
  - out_pc and out_instr come from entry rd_ptr.
  - out_pc_plus4 = out_pc + 4, 32-bit truncated.
  - When out_valid is low, out_pc, out_instr and out_pc_plus4 are don't-care but must be X-free after reset.
- No decoding or alignment checks beyond forcing redirect bits [1:0] to 0.
  - Out-of-range addresses are handled by the instruction memory, which returns NOP 32'h0000_0013; the fetch stage queues that word like any other.
- fetch_en low: pc holds; the queue drains normally.

## Timing
- Reset:
  - pc = RESET_PC, so imem_pc = RESET_PC in the first cycle after reset.
  - count = 0, out_valid = 0.
  - Queue storage is cleared to {0, 32'h0000_0013}.
- rst asserted mid-operation discards all queued entries and any redirect in that cycle. Reset wins over redirect.
- Fetch latency:
  - A push in cycle N gives out_valid = 1 in cycle N+1.
  - Minimum reset-to-first-out_valid is one cycle after rst deasserts.
- Throughput: one instruction per cycle sustained while out_ready = 1.
- Redirect in cycle N:
  - Cycle N+1: out_valid = 0 and imem_pc = redirect target; push at the target.
  - Cycle N+2: out_valid = 1 with out_pc = target.
  - Redirect penalty is 2 cycles.
- Back-to-back redirects: the last one wins; each restarts the sequence above.
- Full queue with out_ready = 0: pc and the queue hold, and head outputs are stable until accepted.
- out_valid, out_pc and out_instr never change while out_valid = 1 and out_ready = 0, except on redirect or reset.

## Test plan
- Reset, then sequential fetch:
  - Stimulus: RESET_PC = 0, out_ready held 1; memory words 0..3 = A0..A3.
  - Response: out_valid rises one cycle after reset; out_pc = 0, 4, 8, 12 on consecutive cycles; out_instr = A0..A3; out_pc_plus4 = out_pc + 4.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles from the first valid.
  - Response: count saturates at DEPTH; imem_pc stalls at 8 (with DEPTH = 2); head stays pc = 0.
  - On release, out_pc continues 0, 4, 8 with no skips or duplicates.
- Full-and-pop:
  - Stimulus: queue full, out_ready = 1 for a single cycle.
  - Response: one push and one pop in the same cycle; count stays DEPTH; imem_pc advances by 4.
- Redirect:
  - Stimulus: redirect_valid pulse with redirect_pc = 32'h0000_0103 while 2 entries are queued.
  - Response: out_valid = 0 the next cycle; out_pc = 32'h0000_0100 two cycles after the pulse; no old entries appear after the redirect.
- Redirect plus pop together:
  - Stimulus: redirect and out_ready = 1 in the same cycle.
  - Response: exactly the old head is consumed; the queue is flushed; the following outputs start at the target.
- Wrap and mid-run reset:
  - Stimulus: redirect to 32'hFFFF_FFF8, then assert rst mid-stream.
  - Response: out_pc = FFFF_FFF8, FFFF_FFFC, 0000_0000 (out_pc_plus4 of FFFF_FFFC is 0).
  - Reset cycle: out_valid = 0 the next cycle; imem_pc = RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction memory
// and buffers {pc, instr} pairs in a small in-order queue feeding decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_plus4
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    logic [31:0]      pc_r;
    logic [31:0]      q_pc_r    [DEPTH];
    logic [31:0]      q_instr_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W:0]   count_r;

    logic             valid_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;

    // Handshake decode; a full queue may still fetch when its head leaves this cycle.
    always_comb begin
        valid_s = 1'b0;
        full_s  = 1'b0;
        pop_s   = 1'b0;
        push_s  = 1'b0;
        if (count_r != (PTR_W + 1)'(1'b0)) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
        full_s = (count_r == DEPTH_C);
        pop_s  = valid_s && out_ready;
        if (fetch_en && !redirect_valid) begin
            push_s = !full_s || pop_s;
        end else begin
            push_s = 1'b0;
        end
    end

    // PC, queue storage, pointers and occupancy; reset beats redirect, redirect beats push.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= {RESET_PC[31:2], 2'b00};
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_r[i]    <= 32'h0000_0000;
                q_instr_r[i] <= NOP;
            end
        end else if (redirect_valid) begin
            pc_r     <= {redirect_pc[31:2], 2'b00};
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                q_pc_r[wr_ptr_r]    <= pc_r;
                q_instr_r[wr_ptr_r] <= imem_instr;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1'b1);
                pc_r                <= pc_r + 32'd4;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1'b1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign imem_pc      = pc_r;
    assign out_valid    = valid_s;
    assign out_pc       = q_pc_r[rd_ptr_r];
    assign out_instr    = q_instr_r[rd_ptr_r];
    assign out_pc_plus4 = q_pc_r[rd_ptr_r] + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-level reference model compared every
// cycle, plus directed literal checks on reset, backpressure, redirect and wrap.
module tb_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_pc_plus4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] m_pc;
    bit          m_known = 1'b0;

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_pc_plus4   (out_pc_plus4)
    );

    always #5 clk = ~clk;

    // Instruction memory: low region tagged with the address, top region tagged, rest NOP.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h0000_0200)      return 32'hA000_0000 | a;
        else if (a >= 32'hFFFF_FF00) return 32'hB000_0000 | {16'h0000, a[15:0]};
        else                         return 32'h0000_0013;
    endfunction

    assign imem_instr = mem_word(imem_pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: compare on the falling edge, then advance to the next state.
    initial begin
        bit pop;
        bit do_push;
        forever begin
            @(negedge clk);
            if (m_known) begin
                chk("imem_pc", imem_pc, m_pc);
                chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
                chk("x_free", {31'b0, $isunknown({out_pc, out_instr, out_pc_plus4})}, 32'h0);
                if (m_q.size() != 0) begin
                    chk("out_pc", out_pc, m_q[0].pc);
                    chk("out_instr", out_instr, m_q[0].instr);
                    chk("out_pc_plus4", out_pc_plus4, m_q[0].pc + 32'd4);
                end
            end
            if (rst) begin
                m_pc = RESET_PC;
                m_q.delete();
                m_known = 1'b1;
            end else if (m_known) begin
                pop = (m_q.size() != 0) && out_ready;
                if (pop) acc_q.push_back(m_q[0].pc);
                if (redirect_valid) begin
                    m_pc = {redirect_pc[31:2], 2'b00};
                    m_q.delete();
                end else begin
                    do_push = fetch_en && ((m_q.size() < DEPTH) || pop);
                    if (pop) void'(m_q.pop_front());
                    if (do_push) begin
                        m_q.push_back({m_pc, mem_word(m_pc)});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] seq_pc    [4];
        logic [31:0] seq_instr [4];
        logic [31:0] pat_fe;
        logic [31:0] pat_rdy;
        seq_pc    = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
        seq_instr = '{32'hA000_0000, 32'hA000_0004, 32'hA000_0008, 32'hA000_000C};
        pat_fe    = 32'b1101_1111_0111_1011_1110_1101_1111_0111;
        pat_rdy   = 32'b1011_0011_1110_0101_1100_1111_0010_1101;

        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; out_ready = 1'b0;
        tick(); tick();
        chk("reset_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_pc", imem_pc, 32'h0000_0000);

        // Sequential fetch with decode always ready
        rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("seq_pc", out_pc, seq_pc[i]);
            chk("seq_instr", out_instr, seq_instr[i]);
            tick();
        end

        // Backpressure from a fresh start at 0
        redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        chk("bp_flush", {31'b0, out_valid}, 32'h0);
        tick();
        repeat (4) tick();
        chk("bp_stall_pc", imem_pc, 32'h0000_0008);
        chk("bp_head", out_pc, 32'h0000_0000);

        // Full queue, single accept cycle
        out_ready = 1'b1;
        tick();
        chk("fp_head", out_pc, 32'h0000_0004);
        chk("fp_pc", imem_pc, 32'h0000_000C);
        out_ready = 1'b0;
        tick();
        chk("hold_head", out_pc, 32'h0000_0004);
        out_ready = 1'b1;
        tick();
        chk("rel_head", out_pc, 32'h0000_0008);

        // Redirect with two entries queued
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        chk("rd_flush", {31'b0, out_valid}, 32'h0);
        chk("rd_imem", imem_pc, 32'h0000_0100);
        tick();
        chk("rd_target", out_pc, 32'h0000_0100);
        tick();

        // Redirect together with a pop
        chk("rp_head", out_pc, 32'h0000_0104);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("rp_acc_last", acc_q[$], 32'h0000_0104);
        chk("rp_acc_prev", acc_q[$-1], 32'h0000_0100);
        chk("rp_flush", {31'b0, out_valid}, 32'h0);
        tick();
        chk("rp_target", out_pc, 32'h0000_0200);

        // Wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        chk("w_flush", {31'b0, out_valid}, 32'h0);
        tick();
        chk("w0_pc", out_pc, 32'hFFFF_FFF8);
        chk("w0_instr", out_instr, 32'hB000_FFF8);
        tick();
        chk("w1_pc", out_pc, 32'hFFFF_FFFC);
        chk("w1_plus4", out_pc_plus4, 32'h0000_0000);
        tick();
        chk("w2_pc", out_pc, 32'h0000_0000);
        chk("w2_instr", out_instr, 32'hA000_0000);

        // Mid-run reset wins over a simultaneous redirect
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        rst = 1'b0; redirect_valid = 1'b0;
        chk("mr_valid", {31'b0, out_valid}, 32'h0);
        chk("mr_pc", imem_pc, RESET_PC);

        // Out-of-range fetch returns a queued NOP
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("nop_pc", out_pc, 32'h0000_1000);
        chk("nop_instr", out_instr, 32'h0000_0013);

        // fetch_en low: drain, PC holds
        fetch_en = 1'b0;
        tick();
        chk("fe_pc", imem_pc, 32'h0000_1004);
        chk("fe_drain", {31'b0, out_valid}, 32'h0);
        tick();
        chk("fe_pc_hold", imem_pc, 32'h0000_1004);

        // Mixed enable/ready pattern with one redirect inside
        for (int i = 0; i < 32; i++) begin
            fetch_en       = pat_fe[i];
            out_ready      = pat_rdy[i];
            redirect_valid = (i == 20);
            redirect_pc    = 32'h0000_0042;
            tick();
        end
        redirect_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
